// File: rtl/barrett_u_precompute_32b_pkg.sv
// Shared widths, iteration count and FSM state encoding for the Barrett
// constant precompute block.
package barrett_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned U_W_DEF    = 2 * DATA_W_DEF;
   localparam int unsigned ITER_COUNT = U_W_DEF + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = S_IDLE,
      ST_CALC = S_CALC,
      ST_DONE = S_DONE
   } state_e;

endpackage

// File: rtl/barrett_u_precompute_32b_if.sv
// Request/result bundle between the Barrett constant precompute block and its
// requester.
interface barrett_u_precompute_32b_if
   import barrett_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned U_W    = U_W_DEF
);
   logic              iEn;
   logic              iClr;
   logic              iStart;
   logic [DATA_W-1:0] iMod;
   logic              oReady;
   logic              oValid;
   logic [U_W-1:0]    oU;
   logic              oErr;

   modport master (
      output iEn, iClr, iStart, iMod,
      input  oReady, oValid, oU, oErr
   );

   modport slave (
      input  iEn, iClr, iStart, iMod,
      output oReady, oValid, oU, oErr
   );
endinterface

// File: rtl/barrett_u_precompute_32b_div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, subtract the
// modulus when it fits, and emit the quotient bit.
module barrett_div_step #(
   parameter int unsigned DATA_W = 32
) (
   input  logic [DATA_W:0]   rem_i,
   input  logic              bit_i,
   input  logic [DATA_W-1:0] mod_i,
   output logic [DATA_W:0]   rem_o,
   output logic              q_o
);
   logic [DATA_W+1:0] shifted;
   logic [DATA_W+1:0] diff;

   // rem_i < mod_i, so the shifted value never reaches the top bit and the
   // difference MSB is a clean borrow flag.
   always_comb begin
      shifted = {rem_i, bit_i};
      diff    = shifted - {2'b00, mod_i};
      q_o     = ~diff[DATA_W+1];
      rem_o   = q_o ? diff[DATA_W:0] : shifted[DATA_W:0];
   end
endmodule

// File: rtl/barrett_u_precompute_32b.sv
// Computes floor(2^U_W / modulus) by sequential restoring division, one
// quotient bit per enabled clock, for loading a Barrett multiplier.
module barrett_u_precompute_32b
   import barrett_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned U_W    = U_W_DEF
) (
   input logic                      iClk,
   input logic                      iRstN,
   barrett_u_precompute_32b_if.slave bus
);
   localparam int unsigned ITERS = U_W + 1;
   localparam int unsigned CNT_W = $clog2(ITERS);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W:0]   rem_q, rem_d;
   logic [U_W:0]      quot_q, quot_d;
   logic [DATA_W-1:0] mod_q, mod_d;
   logic [U_W-1:0]    u_q, u_d;
   logic              err_q, err_d;

   logic [DATA_W:0]   step_rem;
   logic              step_q;
   logic              mod_small;
   logic              last_iter;

   // The quotient register starts holding the dividend 2^U_W: its MSB feeds
   // the divider while quotient bits fill in from the LSB.
   barrett_div_step #(.DATA_W(DATA_W)) u_step (
      .rem_i (rem_q),
      .bit_i (quot_q[U_W]),
      .mod_i (mod_q),
      .rem_o (step_rem),
      .q_o   (step_q)
   );

   assign mod_small = (bus.iMod[DATA_W-1:1] == '0);
   assign last_iter = (cnt_q == CNT_W'(ITERS - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quot_d  = quot_q;
      mod_d   = mod_q;
      u_d     = u_q;
      err_d   = err_q;
      if (bus.iEn) begin
         if (bus.iClr) begin
            state_d = ST_IDLE;
            err_d   = 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (bus.iStart) begin
                     mod_d       = bus.iMod;
                     rem_d       = '0;
                     cnt_d       = '0;
                     quot_d      = '0;
                     quot_d[U_W] = 1'b1;
                     if (mod_small) begin
                        state_d = ST_DONE;
                        u_d     = '1;
                        err_d   = 1'b1;
                     end else begin
                        state_d = ST_CALC;
                     end
                  end
               end
               ST_CALC: begin
                  rem_d  = step_rem;
                  quot_d = {quot_q[U_W-1:0], step_q};
                  cnt_d  = cnt_q + CNT_W'(1);
                  if (last_iter) begin
                     state_d = ST_DONE;
                     u_d     = quot_d[U_W-1:0];
                     err_d   = 1'b0;
                  end
               end
               ST_DONE: state_d = ST_IDLE;
               default: state_d = ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quot_q  <= '0;
         mod_q   <= '0;
         u_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quot_q  <= quot_d;
         mod_q   <= mod_d;
         u_q     <= u_d;
         err_q   <= err_d;
      end
   end

   assign bus.oReady = (state_q == ST_IDLE);
   assign bus.oValid = (state_q == ST_DONE);
   assign bus.oU     = u_q;
   assign bus.oErr   = err_q;
endmodule

// File: tb/tb_barrett_u_precompute_32b.sv
// Self-checking bench for the Barrett constant precompute block: fixed vectors,
// stall/abort/reset sequences and random moduli against an arithmetic model.
module tb_barrett_u_precompute_32b;

   typedef struct {
      logic [31:0] m;
      logic [63:0] exp_u;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   barrett_u_precompute_32b_if #(.DATA_W(32), .U_W(64)) bus ();

   barrett_u_precompute_32b #(.DATA_W(32), .U_W(64)) dut (
      .iClk  (clk),
      .iRstN (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits for IDLE, then presents the request for exactly one edge.
   task automatic do_accept(input logic [31:0] m);
      int unsigned guard;
      guard = 0;
      while (!bus.oReady && guard < 300) begin
         step();
         guard++;
      end
      check("ready_before_start", 64'(bus.oReady), 64'd1);
      bus.iMod   = m;
      bus.iStart = 1'b1;
      step();
      bus.iStart = 1'b0;
      bus.iMod   = $urandom;
   endtask

   // lat counts edges from (and including) the accepting edge.
   task automatic wait_valid(input int lat0, output int lat, output bit timed_out);
      lat = lat0;
      while (!bus.oValid && lat < 400) begin
         step();
         lat++;
      end
      timed_out = !bus.oValid;
   endtask

   function automatic logic [63:0] ref_u(input logic [31:0] m);
      logic [64:0] two64;
      logic [64:0] q;
      two64 = 65'h1_0000_0000_0000_0000;
      q     = two64 / {33'b0, m};
      return q[63:0];
   endfunction

   // Standard Barrett reduction with at most two corrections.
   function automatic logic [31:0] barrett_mod(input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] m, input logic [63:0] u);
      logic [63:0]  x;
      logic [127:0] p;
      logic [63:0]  q;
      logic [63:0]  r;
      x = {32'b0, a} * {32'b0, b};
      p = {64'b0, x} * {64'b0, u};
      q = p[127:64];
      r = x - q * {32'b0, m};
      if (r >= {32'b0, m}) r = r - {32'b0, m};
      if (r >= {32'b0, m}) r = r - {32'b0, m};
      return r[31:0];
   endfunction

   initial begin
      vec_t        vecs[8];
      int          lat;
      bit          to;
      int          seen;
      logic [31:0] m, a, b;
      logic [63:0] x, u_got;

      n_tests = 0;
      n_fail  = 0;
      vecs[0] = '{32'hFFFFFFFF, 64'h0000000100000001, 1'b0, 66};
      vecs[1] = '{32'd2,        64'h8000000000000000, 1'b0, 66};
      vecs[2] = '{32'd3,        64'h5555555555555555, 1'b0, 66};
      vecs[3] = '{32'h80000000, 64'h0000000200000000, 1'b0, 66};
      vecs[4] = '{32'd0,        64'hFFFFFFFFFFFFFFFF, 1'b1, 1};
      vecs[5] = '{32'd1,        64'hFFFFFFFFFFFFFFFF, 1'b1, 1};
      vecs[6] = '{32'd7,        64'h2492492492492492, 1'b0, 66};
      vecs[7] = '{32'd10,       64'h1999999999999999, 1'b0, 66};

      bus.iEn    = 1'b1;
      bus.iClr   = 1'b0;
      bus.iStart = 1'b0;
      bus.iMod   = '0;
      rst_n      = 1'b0;
      #12;
      check("rst_ready", 64'(bus.oReady), 64'd1);
      check("rst_valid", 64'(bus.oValid), 64'd0);
      check("rst_err",   64'(bus.oErr),   64'd0);
      check("rst_u",     bus.oU,          64'd0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 8; i++) begin
         do_accept(vecs[i].m);
         wait_valid(1, lat, to);
         check("vec_timeout", 64'(to), 64'd0);
         check("vec_latency", 64'(lat), 64'(vecs[i].exp_lat));
         check("vec_u",       bus.oU, vecs[i].exp_u);
         check("vec_err",     64'(bus.oErr), 64'(vecs[i].exp_err));
         step();
         check("vec_valid_pulse", 64'(bus.oValid), 64'd0);
         check("vec_ready_after", 64'(bus.oReady), 64'd1);
      end

      // Stall mid-CALC with an ignored start pulse, then hold DONE with iEn low.
      do_accept(32'hFFFFFFFF);
      repeat (9) step();
      bus.iMod   = 32'd5;
      bus.iStart = 1'b1;
      step();
      bus.iStart = 1'b0;
      repeat (9) step();
      bus.iEn = 1'b0;
      repeat (10) step();
      bus.iEn = 1'b1;
      wait_valid(30, lat, to);
      check("stall_timeout", 64'(to), 64'd0);
      check("stall_latency", 64'(lat), 64'd76);
      check("stall_u", bus.oU, 64'h0000000100000001);
      bus.iEn = 1'b0;
      repeat (3) step();
      check("done_hold_valid", 64'(bus.oValid), 64'd1);
      bus.iEn = 1'b1;
      step();
      check("done_release_valid", 64'(bus.oValid), 64'd0);
      check("done_release_ready", 64'(bus.oReady), 64'd1);

      // Abort at iteration 30 after an error result; iStart on the same edge loses.
      do_accept(32'd0);
      wait_valid(1, lat, to);
      check("pre_clr_err", 64'(bus.oErr), 64'd1);
      step();
      do_accept(32'd3);
      repeat (29) step();
      bus.iClr   = 1'b1;
      bus.iStart = 1'b1;
      bus.iMod   = 32'd7;
      step();
      bus.iClr   = 1'b0;
      bus.iStart = 1'b0;
      check("clr_ready", 64'(bus.oReady), 64'd1);
      check("clr_valid", 64'(bus.oValid), 64'd0);
      check("clr_err",   64'(bus.oErr),   64'd0);
      check("clr_u_kept", bus.oU, 64'hFFFFFFFFFFFFFFFF);
      seen = 0;
      repeat (80) begin
         step();
         if (bus.oValid) seen++;
      end
      check("clr_no_valid", 64'(seen), 64'd0);

      // Asynchronous reset at iteration 30.
      do_accept(32'd3);
      repeat (29) step();
      #2 rst_n = 1'b0;
      #1;
      check("midrst_ready", 64'(bus.oReady), 64'd1);
      check("midrst_valid", 64'(bus.oValid), 64'd0);
      check("midrst_err",   64'(bus.oErr),   64'd0);
      check("midrst_u",     bus.oU,          64'd0);
      #1 rst_n = 1'b1;
      seen = 0;
      repeat (80) begin
         step();
         if (bus.oValid) seen++;
      end
      check("midrst_no_valid", 64'(seen), 64'd0);

      for (int i = 0; i < 200; i++) begin
         m = $urandom;
         if (m < 32'd2) m = m + 32'd2;
         do_accept(m);
         wait_valid(1, lat, to);
         check("rnd_latency", 64'(lat), 64'd66);
         check("rnd_u", bus.oU, ref_u(m));
         check("rnd_err", 64'(bus.oErr), 64'd0);
         u_got = bus.oU;
         a = $urandom % m;
         b = $urandom % m;
         x = {32'b0, a} * {32'b0, b};
         check("rnd_barrett", 64'(barrett_mod(a, b, m, u_got)), x % {32'b0, m});
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
